// File: rtl/clk_gate_sched_if.sv
// Request/grant bundle between the consumer blocks and the clock-enable scheduler.
// The scheduler takes the slave side; requesters (or a bench) take the master side.
interface clk_gate_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     ce;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;

  modport master (output req, len, input gnt, ce, busy, done);
  modport slave  (input req, len, output gnt, ce, busy, done);
endinterface

// File: rtl/clk_gate_sched.sv
// Round-robin owner of one gated-clock CE: each granted requester gets a burst of
// ce-high cycles wrapped in ce-low guard cycles, with all outputs straight from flops.
module clk_gate_sched #(
  parameter int NUM_REQ   = 4,
  parameter int LEN_W     = 16,
  parameter int GUARD_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  clk_gate_sched_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [LEN_W-1:0] GUARD_LD = LEN_W'(GUARD_CYC);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, PRE, BURST, POST, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               ce_q, ce_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   pick;
  logic [LEN_W-1:0]   pick_len;

  // Rotating-priority search: first requesting index at or after rr_ptr wins.
  always_comb begin
    found    = 1'b0;
    idx      = rr_ptr_q;
    pick     = rr_ptr_q;
    pick_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick) pick_len = bus.len[i*LEN_W +: LEN_W];
    end
  end

  // One counter serves both guard phases and the burst; it always finishes at 1.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          len_d   = pick_len;
          cnt_d   = GUARD_LD;
          state_d = (pick_len == '0) ? DONE : PRE;
        end
      end
      PRE: begin
        if (!bus.req[win_q]) begin
          state_d = POST;
          cnt_d   = GUARD_LD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = BURST;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BURST: begin
        if (!bus.req[win_q] || cnt_q == CNT_ONE) begin
          state_d = POST;
          cnt_d   = GUARD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      POST: begin
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = IDX_W'((int'(win_q) + 1) % NUM_REQ);
      end
      default: state_d = IDLE;
    endcase

    ce_d   = (state_d == BURST);
    busy_d = (state_d != IDLE);
    gnt_d  = busy_d ? (NUM_REQ'(1) << win_d) : '0;
    done_d = (state_d == DONE) ? (NUM_REQ'(1) << win_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      ce_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      ce_q     <= ce_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.ce   = ce_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_clk_gate_sched.sv
// Randomized scoreboard bench for clk_gate_sched: a service-level round-robin model
// predicts each grant; a negedge monitor measures grants and pops on every done pulse.
module tb_clk_gate_sched;
  localparam int N  = 4;
  localparam int LW = 16;
  localparam int G  = 2;

  typedef struct {
    int win;
    int dur;
    int ce;
    int first_ce;
  } exp_t;
  typedef int arr_t [N];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;
  exp_t sb[$];

  clk_gate_sched_if #(.NUM_REQ(N), .LEN_W(LW)) bus ();

  clk_gate_sched #(.NUM_REQ(N), .LEN_W(LW), .GUARD_CYC(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int remaining(input arr_t v);
    int s = 0;
    for (int i = 0; i < N; i++) s += v[i];
    return s;
  endfunction

  // Monitor: measures each grant from gnt rise to the done pulse.
  int   mon_gcyc = 0;
  int   mon_cecyc = 0;
  int   mon_first_ce = 0;
  int   mon_idle = 1;
  bit   mon_in = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      mon_in   = 1'b0;
      mon_idle = 1;
    end else if (bus.gnt == '0) begin
      checkOutput("gnt_dropped_without_done", int'(mon_in), 0);
      mon_in = 1'b0;
      checkOutput("idle_ce_busy_done", int'({bus.ce, bus.busy, bus.done}), 0);
      mon_idle++;
    end else begin
      if (!mon_in) begin
        checkOutput("idle_gap_before_grant", int'(mon_idle >= 1), 1);
        checkOutput("gnt_onehot", int'($onehot(bus.gnt)), 1);
        mon_in       = 1'b1;
        mon_gcyc     = 0;
        mon_cecyc    = 0;
        mon_first_ce = 0;
      end
      checkOutput("busy_during_grant", int'(bus.busy), 1);
      mon_gcyc++;
      if (bus.ce) begin
        mon_cecyc++;
        if (mon_first_ce == 0) mon_first_ce = mon_gcyc;
      end
      if (bus.done != '0) begin
        checkOutput("expect_pending_at_done", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("winner_gnt", int'(bus.gnt), 1 << mon_e.win);
          checkOutput("winner_done", int'(bus.done), 1 << mon_e.win);
          checkOutput("gnt_cycles", mon_gcyc, mon_e.dur);
          checkOutput("ce_high_cycles", mon_cecyc, mon_e.ce);
          checkOutput("ce_first_cycle", mon_first_ce, mon_e.first_ce);
        end
        mon_in   = 1'b0;
        mon_idle = 0;
      end
    end
  end

  // Model: serve requesters with remaining count>0 in rotating order, then drive them.
  task automatic applyStimulus(input arr_t lens, input arr_t cnt, input arr_t abk);
    arr_t r;
    arr_t gc;
    arr_t cc;
    int   ptr;
    int   w;
    int   ce_n;
    int   dur;
    int   budget;
    int   cyc;
    exp_t x;
    r      = cnt;
    ptr    = model_ptr;
    budget = 20;
    while (remaining(r) > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && r[(ptr + k) % N] > 0) w = (ptr + k) % N;
      end
      if (lens[w] == 0) begin
        ce_n = 0;
        dur  = 1;
      end else if (r[w] == 1 && abk[w] == 0) begin
        ce_n = 0;
        dur  = 1 + G + 1;
      end else if (r[w] == 1 && abk[w] > 0) begin
        ce_n = (abk[w] < lens[w]) ? abk[w] : lens[w];
        dur  = G + ce_n + G + 1;
      end else begin
        ce_n = lens[w];
        dur  = 2 * G + lens[w] + 1;
      end
      x.win      = w;
      x.dur      = dur;
      x.ce       = ce_n;
      x.first_ce = (ce_n > 0) ? G + 1 : 0;
      sb.push_back(x);
      budget += dur + 2;
      r[w]--;
      ptr = (w + 1) % N;
    end
    model_ptr = ptr;

    r = cnt;
    for (int i = 0; i < N; i++) begin
      gc[i] = 0;
      cc[i] = 0;
      bus.len[i*LW +: LW] = LW'(lens[i]);
      bus.req[i] = (r[i] > 0);
    end
    cyc = 0;
    while (remaining(r) > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          if (bus.done[i]) begin
            r[i]--;
            if (r[i] == 0) bus.req[i] = 1'b0;
            gc[i] = 0;
            cc[i] = 0;
          end else begin
            gc[i]++;
            if (bus.ce) cc[i]++;
            if (r[i] == 1 && bus.req[i]) begin
              if (abk[i] == 0 && gc[i] == 1) bus.req[i] = 1'b0;
              else if (abk[i] > 0 && bus.ce && cc[i] == abk[i]) bus.req[i] = 1'b0;
            end
          end
        end
      end
    end
    checkOutput("round_services_left", remaining(r), 0);
    bus.req = '0;
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    arr_t l;
    arr_t c;
    arr_t a;
    int   n;
    bus.req = '0;
    bus.len = '0;
    #1 rst = 1'b1;
    #1;
    checkOutput("por_ce", int'(bus.ce === 1'b0), 1);
    checkOutput("por_gnt", int'(bus.gnt === '0), 1);
    checkOutput("por_busy", int'(bus.busy === 1'b0), 1);
    checkOutput("por_done", int'(bus.done === '0), 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // All four held, len 3: order 0,1,2,3,0.
    l = '{3, 3, 3, 3}; c = '{2, 1, 1, 1}; a = '{-1, -1, -1, -1};
    applyStimulus(l, c, a);
    l = '{5, 0, 0, 0}; c = '{1, 0, 0, 0};
    applyStimulus(l, c, a);
    // Zero-length grant on requester 2, then a full round exposes rr_ptr=3.
    l = '{0, 0, 0, 0}; c = '{0, 0, 1, 0};
    applyStimulus(l, c, a);
    l = '{1, 2, 1, 2}; c = '{1, 1, 1, 1};
    applyStimulus(l, c, a);
    // Abort on the 10th burst cycle of a 100-cycle burst.
    l = '{0, 100, 0, 0}; c = '{0, 1, 0, 0}; a = '{-1, 10, -1, -1};
    applyStimulus(l, c, a);

    // Asynchronous reset in the middle of a burst.
    bus.len[1*LW +: LW] = 16'd50;
    bus.req = 4'b0010;
    n = 0;
    for (int k = 0; k < 200 && n < 20; k++) begin
      @(negedge clk);
      if (bus.ce) n++;
    end
    checkOutput("midburst_ce_seen", n, 20);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ce", int'(bus.ce === 1'b0), 1);
    checkOutput("async_rst_gnt", int'(bus.gnt === '0), 1);
    checkOutput("async_rst_busy", int'(bus.busy === 1'b0), 1);
    checkOutput("async_rst_done", int'(bus.done === '0), 1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    l = '{4, 0, 0, 2}; c = '{1, 0, 0, 1}; a = '{-1, -1, -1, -1};
    applyStimulus(l, c, a);

    // Maximum burst length.
    l = '{0, 0, 0, 65535}; c = '{0, 0, 0, 1};
    applyStimulus(l, c, a);

    for (int rnd = 0; rnd < 25; rnd++) begin
      for (int i = 0; i < N; i++) begin
        c[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
        l[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
        a[i] = (l[i] > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l[i])) : -1;
      end
      if (remaining(c) == 0) c[$urandom_range(0, N - 1)] = 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(l, c, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
